// File: rtl/decode_issue_buffer.sv
// Decode issue buffer: 4-entry FIFO between fetch/decode latch and decode.
// Accepts two-wide fetch packets and offers up to two entries for dual issue.
module decode_issue_buffer (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        flush,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr0,
  input  logic [31:0] in_instr1,
  input  logic        in_valid0,
  input  logic        in_valid1,
  output logic        fd_ready,
  input  logic        dec_accept,
  output logic [31:0] out_pc0,
  output logic [31:0] out_instr0,
  output logic        out_valid0,
  output logic [31:0] out_pc1,
  output logic [31:0] out_instr1,
  output logic        out_valid1
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t     mem_q [4];
  logic [1:0] head_q, head_d;
  logic [1:0] tail_q, tail_d;
  logic [2:0] count_q, count_d;

  logic [1:0] head1;
  logic [1:0] tail1;
  entry_t     e0, e1;
  logic [4:0] op0;
  logic [4:0] rd0;
  logic       ctrl_op;
  logic       raw;
  logic       v0, v1;
  logic [1:0] pop_n;
  logic [1:0] push_n;
  logic       wa_en, wb_en;
  entry_t     wa, wb;
  entry_t     s0, s1;

  assign head1 = head_q + 2'd1;
  assign tail1 = tail_q + 2'd1;
  assign e0    = mem_q[head_q];
  assign e1    = mem_q[head1];
  assign op0   = e0.instr[31:27];
  assign rd0   = e0.instr[26:22];

  always_comb begin
    ctrl_op = 1'b0;
    unique case (1'b1)
      op0 == 5'b00001,
      op0 == 5'b00010,
      op0 == 5'b00011,
      op0 == 5'b00100,
      op0 == 5'b00110: ctrl_op = 1'b1;
      default:         ctrl_op = 1'b0;
    endcase
  end

  // Second slot may not read what the head writes (r0 never hazards)
  assign raw = (rd0 != 5'd0) &&
               ((rd0 == e1.instr[21:17]) ||
                (rd0 == e1.instr[16:12]));

  assign fd_ready = (count_q <= 3'd2);
  assign v0       = (count_q != 3'd0);
  assign v1       = (count_q >= 3'd2) && !ctrl_op && !raw;

  assign out_valid0 = v0;
  assign out_valid1 = v1;
  assign out_pc0    = v0 ? e0.pc    : 32'd0;
  assign out_instr0 = v0 ? e0.instr : 32'd0;
  assign out_pc1    = v1 ? e1.pc    : 32'd0;
  assign out_instr1 = v1 ? e1.instr : 32'd0;

  assign pop_n = dec_accept ?
                 ({1'b0, v0} + {1'b0, v1}) : 2'd0;

  assign s0 = '{pc: in_pc,         instr: in_instr0};
  assign s1 = '{pc: in_pc + 32'd4, instr: in_instr1};

  always_comb begin
    wa_en = 1'b0;
    wb_en = 1'b0;
    wa    = s0;
    wb    = s1;
    if (fd_ready && !flush) begin
      if (in_valid0) begin
        wa_en = 1'b1;
        wb_en = in_valid1;
      end else if (in_valid1) begin
        wa_en = 1'b1;
        wa    = s1;
      end
    end
  end

  assign push_n = {1'b0, wa_en} + {1'b0, wb_en};

  always_comb begin
    head_d  = head_q + pop_n;
    tail_d  = tail_q + push_n;
    count_d = count_q + {1'b0, push_n} - {1'b0, pop_n};
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset || flush) begin
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      if (wa_en) mem_q[tail_q] <= wa;
      if (wb_en) mem_q[tail1]  <= wb;
    end
  end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Bench for decode_issue_buffer: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_decode_issue_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        flush;
  logic [31:0] in_pc;
  logic [31:0] in_instr0;
  logic [31:0] in_instr1;
  logic        in_valid0;
  logic        in_valid1;
  logic        fd_ready;
  logic        dec_accept;
  logic [31:0] out_pc0;
  logic [31:0] out_instr0;
  logic        out_valid0;
  logic [31:0] out_pc1;
  logic [31:0] out_instr1;
  logic        out_valid1;

  int total = 0;
  int bad   = 0;
  ent_t q[$];

  decode_issue_buffer dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .flush      (flush),
    .in_pc      (in_pc),
    .in_instr0  (in_instr0),
    .in_instr1  (in_instr1),
    .in_valid0  (in_valid0),
    .in_valid1  (in_valid1),
    .fd_ready   (fd_ready),
    .dec_accept (dec_accept),
    .out_pc0    (out_pc0),
    .out_instr0 (out_instr0),
    .out_valid0 (out_valid0),
    .out_pc1    (out_pc1),
    .out_instr1 (out_instr1),
    .out_valid1 (out_valid1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(
    input int op, input int rd, input int rs, input int rt);
    logic [4:0] o, d, s, t;
    o = op[4:0];
    d = rd[4:0];
    s = rs[4:0];
    t = rt[4:0];
    return {o, d, s, t, 12'h0};
  endfunction

  function automatic bit pair_ok(input ent_t a, input ent_t b);
    int op, rd, rs, rt;
    op = int'(a.instr[31:27]);
    rd = int'(a.instr[26:22]);
    rs = int'(b.instr[21:17]);
    rt = int'(b.instr[16:12]);
    if (op inside {1, 2, 3, 4, 6}) return 0;
    if (rd != 0 && (rd == rs || rd == rt)) return 0;
    return 1;
  endfunction

  function automatic bit m_v1();
    return q.size() >= 2 && pair_ok(q[0], q[1]);
  endfunction

  task automatic check_all();
    bit   v0, v1;
    ent_t z;
    z  = '0;
    v0 = q.size() >= 1;
    v1 = m_v1();
    chk("ready",  fd_ready,   q.size() <= 2);
    chk("valid0", out_valid0, v0);
    chk("valid1", out_valid1, v1);
    chk("pc0",    out_pc0,    v0 ? q[0].pc    : z.pc);
    chk("instr0", out_instr0, v0 ? q[0].instr : z.instr);
    chk("pc1",    out_pc1,    v1 ? q[1].pc    : z.pc);
    chk("instr1", out_instr1, v1 ? q[1].instr : z.instr);
  endtask

  // Advance one clock and apply the same inputs to the model.
  task automatic cycle();
    bit   rdy;
    int   pops;
    ent_t s0, s1;
    rdy  = q.size() <= 2;
    pops = 0;
    if (dec_accept) pops = (q.size() >= 1) + m_v1();
    s0 = '{pc: in_pc, instr: in_instr0};
    s1 = '{pc: in_pc + 32'd4, instr: in_instr1};
    @(posedge clock);
    #1;
    if (ctrl_reset || flush) begin
      q.delete();
    end else begin
      for (int i = 0; i < pops; i++) void'(q.pop_front());
      if (rdy && in_valid0) q.push_back(s0);
      if (rdy && in_valid1) q.push_back(s1);
    end
    check_all();
  endtask

  task automatic drive(input logic [31:0] pc,
                       input logic [31:0] i0,
                       input logic [31:0] i1,
                       input logic v0, input logic v1,
                       input logic acc, input logic fl);
    in_pc      = pc;
    in_instr0  = i0;
    in_instr1  = i1;
    in_valid0  = v0;
    in_valid1  = v1;
    dec_accept = acc;
    flush      = fl;
    cycle();
  endtask

  task automatic idle(input logic acc);
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, acc, 1'b0);
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b1;
    idle(1'b0);
    ctrl_reset = 1'b0;
  endtask

  initial begin
    ctrl_reset = 1'b1;
    flush      = 1'b0;
    in_pc      = 32'h0;
    in_instr0  = 32'h0;
    in_instr1  = 32'h0;
    in_valid0  = 1'b0;
    in_valid1  = 1'b0;
    dec_accept = 1'b0;
    do_reset();
    chk("rst_ready",  fd_ready,   1);
    chk("rst_valid0", out_valid0, 0);
    chk("rst_pc0",    out_pc0,    0);

    // dual push of independent ALU ops
    drive(32'h100, mk(0, 1, 2, 3), mk(0, 4, 5, 6),
          1, 1, 0, 0);
    chk("d_pc0",   out_pc0,    32'h100);
    chk("d_pc1",   out_pc1,    32'h104);
    chk("d_v1",    out_valid1, 1);
    chk("d_ready", fd_ready,   1);

    // fill to four, third packet dropped, then drain two
    drive(32'h108, mk(0, 7, 8, 9), mk(0, 10, 11, 12),
          1, 1, 0, 0);
    chk("full_ready", fd_ready, 0);
    drive(32'h200, mk(0, 1, 1, 1), mk(0, 2, 2, 2),
          1, 1, 0, 0);
    chk("full_pc0", out_pc0, 32'h100);
    idle(1'b1);
    chk("drain_ready", fd_ready, 1);
    chk("drain_pc0",   out_pc0,  32'h108);

    // RAW hazard splits the pair
    do_reset();
    drive(32'h300, mk(0, 5, 1, 2), mk(0, 7, 5, 3),
          1, 1, 0, 0);
    chk("raw_v1", out_valid1, 0);
    idle(1'b1);
    chk("raw_v0",   out_valid0, 1);
    chk("raw_pc0",  out_pc0,    32'h304);
    chk("raw_ins0", out_instr0, mk(0, 7, 5, 3));

    // branch at head blocks pairing; r0 never hazards
    do_reset();
    drive(32'h400, mk(2, 1, 2, 3), mk(0, 4, 5, 6),
          1, 1, 0, 0);
    chk("bne_v1", out_valid1, 0);
    do_reset();
    drive(32'h400, mk(0, 0, 1, 2), mk(0, 3, 0, 0),
          1, 1, 0, 0);
    chk("r0_v1", out_valid1, 1);

    // slot1-only push takes pc+4
    do_reset();
    drive(32'h500, mk(0, 1, 2, 3), mk(0, 9, 9, 9),
          0, 1, 0, 0);
    chk("s1_pc0", out_pc0, 32'h504);

    // wrap the tail, then flush alongside push and pop
    do_reset();
    drive(32'h600, mk(0, 1, 2, 3), mk(0, 4, 5, 6),
          1, 1, 0, 0);
    idle(1'b1);
    drive(32'h608, mk(0, 1, 2, 3), mk(0, 4, 5, 6),
          1, 1, 0, 0);
    drive(32'h610, mk(0, 7, 2, 3), mk(0, 4, 5, 6),
          1, 0, 0, 0);
    chk("wrap_ready", fd_ready, 0);
    chk("wrap_pc0",   out_pc0,  32'h608);
    drive(32'h700, mk(0, 1, 2, 3), mk(0, 4, 5, 6),
          1, 1, 1, 1);
    chk("fl_v0",    out_valid0, 0);
    chk("fl_ready", fd_ready,   1);

    // reset during push and pop at count two
    do_reset();
    drive(32'h800, mk(0, 1, 2, 3), mk(0, 4, 5, 6),
          1, 1, 0, 0);
    ctrl_reset = 1'b1;
    drive(32'h808, mk(0, 1, 2, 3), mk(0, 4, 5, 6),
          1, 1, 1, 0);
    ctrl_reset = 1'b0;
    chk("mr_v0",    out_valid0, 0);
    chk("mr_v1",    out_valid1, 0);
    chk("mr_pc1",   out_pc1,    0);
    chk("mr_ready", fd_ready,   1);

    // random traffic with narrow register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      ctrl_reset = ($urandom_range(0, 99) == 0);
      drive({$urandom, 2'b00} & 32'h0000_fffc,
            mk($urandom_range(0, 7), $urandom_range(0, 5),
               $urandom_range(0, 5), $urandom_range(0, 5)),
            mk($urandom_range(0, 7), $urandom_range(0, 5),
               $urandom_range(0, 5), $urandom_range(0, 5)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 29) == 0));
    end
    ctrl_reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_issue_buffer.md
DECODE_ISSUE_BUFFER -- requirements
Module: decode_issue_buffer

Interface
REQ-001 The module SHALL have one clock and synchronous, active-high reset. Ports listed as: name direction width meaning.
REQ-002 clock input 1: rising-edge clock for all state.
REQ-003 ctrl_reset input 1: synchronous, active-high reset.
REQ-004 flush input 1: synchronous buffer clear on branch/jump redirect.
REQ-005 in_pc input 32: PC of fetch slot 0; slot 1 PC is in_pc+4 (mod 2^32).
REQ-006 in_instr0 input 32 and in_instr1 input 32: fetched instruction words for slots 0 and 1.
REQ-007 in_valid0 input 1 and in_valid1 input 1: slot valid flags from the fetch/decode latch.
REQ-008 fd_ready output 1: buffer can take a full two-wide packet this cycle; drives the fetch/decode latch write enables.
REQ-009 dec_accept input 1: decode stage consumes every currently valid output slot this cycle.
REQ-010 out_pc0/out_instr0 output 32 each, and out_valid0 output 1: oldest entry.
REQ-011 out_pc1/out_instr1 output 32 each, and out_valid1 output 1: second-oldest entry, dual-issue only.

Function
REQ-012 Storage SHALL be a 4-entry circular FIFO of {pc[31:0], instr[31:0]}, with 2-bit head/tail pointers that wrap 3->0 and a 3-bit count in 0..4.
REQ-013 fd_ready SHALL be 1 iff registered count <= 2, independent of same-cycle dequeue.
REQ-014 Push SHALL occur only when fd_ready=1. In-valid slots are written in order slot0 then slot1. in_valid1 alone writes one entry with pc=in_pc+4.
REQ-015 When fd_ready=0, input slots SHALL be ignored with no state change from them.
REQ-016 out_valid0 SHALL be 1 iff count >= 1. out_pc0/out_instr0 = entry[head], else 0.
REQ-017 out_valid1 SHALL be 1 iff count >= 2 and pairing is legal. out_pc1/out_instr1 = entry[head+1], else 0.
REQ-018 Instruction fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12].
REQ-019 Pairing SHALL be illegal when the head opcode is 00001, 00010, 00011, 00100 or 00110 (control ops).
REQ-020 Pairing SHALL also be illegal when head rd != 0 and head rd equals the second entry's rs or rt.
REQ-021 Pop count SHALL be out_valid0+out_valid1 when dec_accept=1, else 0. dec_accept with count=0 SHALL have no effect.
REQ-022 Next count = count + pushes - pops, with push and pop in the same cycle allowed. Since count<=2 at push, count SHALL never exceed 4 or underflow.
REQ-023 All outputs SHALL be combinational from registered state only, with no input-to-output path.
REQ-024 Flush SHALL set head=tail=count=0 next cycle and SHALL discard same-cycle pushes and pops.

Reset
REQ-025 ctrl_reset SHALL have priority over flush, push and pop. Next edge: head=tail=count=0 and entry contents are don't-care.
REQ-026 After reset: fd_ready=1, out_valid0=out_valid1=0, all out_pc/out_instr=0.
REQ-027 Reset asserted mid-operation SHALL discard all entries in one cycle with no partial commit.

Verification
REQ-028 After reset, push in_pc=0x100 with independent ALU instrs in both slots, dec_accept=0 -> next cycle count=2, out_pc0=0x100, out_pc1=0x104, both valid, fd_ready=1.
REQ-029 Two dual pushes with dec_accept=0 -> count=4, fd_ready=0. A third packet is ignored. Then dec_accept=1 -> count=2, fd_ready=1.
REQ-030 Head rd=5 and second rs=5 -> out_valid1=0. With dec_accept=1, one entry pops and the second becomes head with out_valid0=1.
REQ-031 Head opcode 00010 (bne) -> out_valid1=0 even with no register overlap. With head rd=0 and second rs=0, pairing is legal.
REQ-032 Fill to count=3 with wrapped pointers (tail passes 3->0), then flush together with a push and dec_accept -> next cycle count=0, out_valid0=0, fd_ready=1.
REQ-033 Assert ctrl_reset during a simultaneous push and pop at count=2 -> next cycle all outputs reset to REQ-026 values.
